frame_pixel_streamer: RTL and testbench
=======================================

Name: frame_pixel_streamer

Overview:
- Synthesizable pixel source that replays a stored frame from a synchronous frame-buffer SRAM as a raster pixel stream (`pixel`/`vld`) into the CNN accelerator input path.
- It is the transmitter counterpart of the bmp image writer sink.
- Frame timing is programmable: width, height, start-up delay and inter-row (hsync) delay, matching the accelerator's FRAME_SIZE, WIDTH_HEIGHT and DELAY_PARAMS register fields.
- One frame is emitted per start pulse, with a one-cycle frame-done pulse at the end.

Parameters:
- W_SIZE, 12, width of width/height fields and row/col counters.
- W_DELAY, 12, width of start-up/hsync delay fields.
- W_PIX, 32, pixel word width (4 channels x 8 bit packed).
- W_ADDR, 16, frame-buffer word address width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle start pulse; honoured only in IDLE.
- i_width  in  W_SIZE  pixels per row; latched at start.
- i_height  in  W_SIZE  rows per frame; latched at start.
- i_start_up_delay  in  W_DELAY  idle cycles before first row read; latched at start.
- i_hsync_delay  in  W_DELAY  idle cycles between rows; latched at start.
- o_mem_re  out  1  frame-buffer read enable.
- o_mem_addr  out  W_ADDR  frame-buffer word address.
- i_mem_rdata  in  W_PIX  read data, valid exactly 1 cycle after o_mem_re.
- o_pixel  out  W_PIX  output pixel, registered.
- o_vld  out  1  o_pixel valid.
- o_sol  out  1  high with o_vld on the first pixel of each row.
- o_sof  out  1  high with o_vld on the first pixel of the frame.
- o_busy  out  1  high from the cycle after an accepted start until o_frame_done inclusive.
- o_frame_done  out  1  one-cycle pulse after the last o_vld.

Behaviour:
- Reset: all outputs 0 (o_pixel = 0, o_mem_addr = 0); FSM to IDLE; counters cleared. Reset mid-frame aborts immediately; no o_frame_done is issued; the next start begins a fresh frame at address 0.
- FSM states: IDLE, STARTUP, ROW, HBLANK, DRAIN.
- IDLE, i_start = 1:
  - latch config;
  - width = 0 or height = 0 → DRAIN (frame_done only, no reads);
  - else start_up_delay > 0 → STARTUP;
  - else → ROW.
- STARTUP: exactly start_up_delay cycles, then ROW.
- ROW: o_mem_re = 1 for exactly width consecutive cycles. Address starts at 0 and increments by 1 per read, continuing across rows (addr = row*width + col), wrapping modulo 2^W_ADDR. After the last column:
  - if last row → DRAIN;
  - else hsync_delay > 0 → HBLANK;
  - else → ROW directly (back-to-back rows, no gap).
- HBLANK: exactly hsync_delay cycles with o_mem_re = 0, then ROW.
- Read pipeline: mem_re in cycle N → rdata sampled in N+1 → o_pixel/o_vld in cycle N+2. Total latency 2; o_vld is o_mem_re delayed by 2 cycles. o_sol/o_sof are delayed with the same pipeline.
- o_pixel holds its last value when o_vld = 0.
- DRAIN: wait until the pipeline is empty. Pulse o_frame_done in the cycle after the last o_vld (for an empty frame, the cycle after entering DRAIN). Return to IDLE in the same cycle; o_busy falls the following cycle.
- i_start while not IDLE: ignored. Config inputs changing mid-frame: ignored.
- Start in the same cycle the FSM re-enters IDLE after a frame: accepted on the next cycle only (IDLE must be registered).
- Total vld count per frame = width*height. Row/col counters use W_SIZE bits and saturate-free compares on the latched values.

Test Plan:
- width 4, height 2, start_up 3, hsync 2, mem[k] = 32'h100+k, start at cycle 0:
  - mem_re in cycles 4–7 (addr 0–3) and 10–13 (addr 4–7);
  - o_vld in cycles 6–9 and 12–15, pixels 0x100–0x107;
  - o_sof at 6; o_sol at 6 and 12;
  - o_frame_done at 16.
- width 3, height 3, delays 0: mem_re in cycles 1–9 contiguous, addr 0–8; o_vld 3–11; o_sol at 3, 6, 9; frame_done at 12.
- width 0, height 5: no mem_re, no o_vld; o_frame_done one pulse; o_busy high for exactly the pulse window.
- Second i_start pulsed mid-frame, and width input changed to 7 mid-frame: frame unaffected, exactly 8 vld; only one frame_done.
- rst asserted in cycle 8 of the first scenario: all outputs 0 at cycle 9; a restart then replays from addr 0 with o_sof on the first pixel.
- width 256, height 256, W_ADDR 16: last addr 0xFFFF; 65536 vld; address wraps to 0 on the next frame.

Source files
------------

// File: rtl/frame_pixel_streamer.sv
// Replays a stored frame from the frame-buffer SRAM as a raster pixel stream.
// Programmable width/height, start-up delay and inter-row gap; 2-cycle read pipeline.
module frame_pixel_streamer #(
  parameter int W_SIZE  = 12,
  parameter int W_DELAY = 12,
  parameter int W_PIX   = 32,
  parameter int W_ADDR  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic [W_SIZE-1:0]  i_width,
  input  logic [W_SIZE-1:0]  i_height,
  input  logic [W_DELAY-1:0] i_start_up_delay,
  input  logic [W_DELAY-1:0] i_hsync_delay,
  output logic               o_mem_re,
  output logic [W_ADDR-1:0]  o_mem_addr,
  input  logic [W_PIX-1:0]   i_mem_rdata,
  output logic [W_PIX-1:0]   o_pixel,
  output logic               o_vld,
  output logic               o_sol,
  output logic               o_sof,
  output logic               o_busy,
  output logic               o_frame_done
);

  typedef enum logic [2:0] {
    IDLE, STARTUP, ROW, HBLANK, DRAIN
  } state_t;

  state_t state;

  logic [W_SIZE-1:0]  width_q;
  logic [W_SIZE-1:0]  height_q;
  logic [W_DELAY-1:0] su_q;
  logic [W_DELAY-1:0] hs_q;
  logic [W_SIZE-1:0]  col;
  logic [W_SIZE-1:0]  row;
  logic [W_DELAY-1:0] dcnt;
  logic               re_d1;
  logic               sol_d1;
  logic               sof_d1;
  logic               last_col;
  logic               last_row;
  logic               first_col;

  assign o_mem_re  = (state == ROW);
  assign last_col  = (col == width_q - W_SIZE'(1));
  assign last_row  = (row == height_q - W_SIZE'(1));
  assign first_col = (col == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      width_q      <= '0;
      height_q     <= '0;
      su_q         <= '0;
      hs_q         <= '0;
      col          <= '0;
      row          <= '0;
      dcnt         <= '0;
      o_mem_addr   <= '0;
      re_d1        <= 1'b0;
      sol_d1       <= 1'b0;
      sof_d1       <= 1'b0;
      o_pixel      <= '0;
      o_vld        <= 1'b0;
      o_sol        <= 1'b0;
      o_sof        <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      // Row/frame markers ride the same 2-stage pipe as the read data.
      re_d1  <= o_mem_re;
      sol_d1 <= o_mem_re && first_col;
      sof_d1 <= o_mem_re && first_col && (row == '0);
      o_vld  <= re_d1;
      o_sol  <= sol_d1;
      o_sof  <= sof_d1;
      if (re_d1) o_pixel <= i_mem_rdata;
      if (o_frame_done) o_busy <= 1'b0;

      unique case (state)
        IDLE: begin
          if (i_start) begin
            width_q    <= i_width;
            height_q   <= i_height;
            su_q       <= i_start_up_delay;
            hs_q       <= i_hsync_delay;
            col        <= '0;
            row        <= '0;
            dcnt       <= '0;
            o_mem_addr <= '0;
            o_busy     <= 1'b1;
            if (i_width == '0 || i_height == '0)
              state <= DRAIN;
            else if (i_start_up_delay != '0)
              state <= STARTUP;
            else
              state <= ROW;
          end
        end
        STARTUP: begin
          if (dcnt == su_q - W_DELAY'(1)) begin
            dcnt  <= '0;
            state <= ROW;
          end else begin
            dcnt <= dcnt + W_DELAY'(1);
          end
        end
        ROW: begin
          o_mem_addr <= o_mem_addr + W_ADDR'(1);
          if (last_col) begin
            col <= '0;
            row <= row + W_SIZE'(1);
            if (last_row)
              state <= DRAIN;
            else if (hs_q != '0) begin
              dcnt  <= '0;
              state <= HBLANK;
            end
          end else begin
            col <= col + W_SIZE'(1);
          end
        end
        HBLANK: begin
          if (dcnt == hs_q - W_DELAY'(1)) begin
            dcnt  <= '0;
            state <= ROW;
          end else begin
            dcnt <= dcnt + W_DELAY'(1);
          end
        end
        DRAIN: begin
          if (!re_d1) begin
            o_frame_done <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Scoreboard bench for frame_pixel_streamer: predicted reads, pixels and
// frame-done pulses are queued at start and matched cycle-exactly.
module tb_frame_pixel_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [11:0] i_width = '0;
  logic [11:0] i_height = '0;
  logic [11:0] i_su = '0;
  logic [11:0] i_hs = '0;
  logic        re;
  logic [15:0] addr;
  logic [31:0] rdata = '0;
  logic [31:0] pixel;
  logic        vld;
  logic        sol;
  logic        sof;
  logic        busy;
  logic        done;

  frame_pixel_streamer dut (
    .clk              (clk),
    .rst              (rst),
    .i_start          (i_start),
    .i_width          (i_width),
    .i_height         (i_height),
    .i_start_up_delay (i_su),
    .i_hsync_delay    (i_hs),
    .o_mem_re         (re),
    .o_mem_addr       (addr),
    .i_mem_rdata      (rdata),
    .o_pixel          (pixel),
    .o_vld            (vld),
    .o_sol            (sol),
    .o_sof            (sof),
    .o_busy           (busy),
    .o_frame_done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] a;
  } rd_t;

  typedef struct {
    int          cyc;
    logic [31:0] px;
    logic        sl;
    logic        sf;
  } px_t;

  rd_t  rdq[$];
  px_t  pxq[$];
  int   dq[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   nvld = 0;
  int   ndone = 0;
  bit   mon_en = 1'b0;
  logic [31:0] last_px = '0;

  function automatic logic [31:0] memval(logic [15:0] a);
    return 32'h100 + {16'h0, a};
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) if (re) rdata <= memval(addr);

  always @(negedge clk) begin
    rd_t r;
    px_t p;
    int  d;
    if (mon_en) begin
      if (re) begin
        total++;
        if (rdq.size() == 0) begin
          bad++;
          $display("FAIL rd_extra cyc=%0d addr=%h", cyc, addr);
        end else begin
          r = rdq.pop_front();
          if (r.cyc !== cyc || r.a !== addr) begin
            bad++;
            $display("FAIL rd cyc=%0d addr=%h want cyc=%0d addr=%h",
                     cyc, addr, r.cyc, r.a);
          end
        end
      end
      if (vld) begin
        nvld++;
        total++;
        if (pxq.size() == 0) begin
          bad++;
          $display("FAIL vld_extra cyc=%0d px=%h", cyc, pixel);
        end else begin
          p = pxq.pop_front();
          if (p.cyc !== cyc || p.px !== pixel || p.sl !== sol || p.sf !== sof) begin
            bad++;
            $display("FAIL px cyc=%0d px=%h sol=%b sof=%b want cyc=%0d px=%h sol=%b sof=%b",
                     cyc, pixel, sol, sof, p.cyc, p.px, p.sl, p.sf);
          end
        end
        last_px = pixel;
      end else begin
        total++;
        if (pixel !== last_px || sol !== 1'b0 || sof !== 1'b0) begin
          bad++;
          $display("FAIL hold cyc=%0d px=%h sol=%b sof=%b want px=%h sol=0 sof=0",
                   cyc, pixel, sol, sof, last_px);
        end
      end
      if (done) begin
        ndone++;
        total++;
        if (dq.size() == 0) begin
          bad++;
          $display("FAIL done_extra cyc=%0d", cyc);
        end else begin
          d = dq.pop_front();
          if (d !== cyc) begin
            bad++;
            $display("FAIL done cyc=%0d want %0d", cyc, d);
          end
        end
      end
    end
  end

  task automatic push_frame(int s, int w, int h, int su, int hs);
    int rc;
    rc = 0;
    if (w == 0 || h == 0) begin
      dq.push_back(s + 2);
      return;
    end
    for (int i = 0; i < h; i++) begin
      for (int j = 0; j < w; j++) begin
        logic [15:0] a;
        rc = s + 1 + su + i * (w + hs) + j;
        a  = 16'(i * w + j);
        rdq.push_back('{cyc: rc, a: a});
        pxq.push_back('{cyc: rc + 2, px: memval(a), sl: (j == 0),
                        sf: (i == 0 && j == 0)});
      end
    end
    dq.push_back(rc + 3);
  endtask

  task automatic start_frame(int w, int h, int su, int hs, output int s);
    @(posedge clk);
    #1;
    i_width  = 12'(w);
    i_height = 12'(h);
    i_su     = 12'(su);
    i_hs     = 12'(hs);
    i_start  = 1'b1;
    s        = cyc;
    push_frame(s, w, h, su, hs);
    @(posedge clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic flush();
    rdq.delete();
    pxq.delete();
    dq.delete();
  endtask

  task automatic wait_idle(int limit);
    int n;
    n = 0;
    while ((rdq.size() + pxq.size() + dq.size()) != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    total++;
    if ((rdq.size() + pxq.size() + dq.size()) != 0) begin
      bad++;
      $display("FAIL timeout rd=%0d px=%0d done=%0d left, want 0",
               rdq.size(), pxq.size(), dq.size());
      flush();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({re, addr, pixel, vld, sol, sof, busy, done} !== '0) begin
      bad++;
      $display("FAIL reset re=%b addr=%h px=%h vld=%b sol=%b sof=%b busy=%b done=%b want all 0",
               re, addr, pixel, vld, sol, sof, busy, done);
    end
    @(posedge clk);
    #1;
    rst     = 1'b0;
    last_px = '0;
    mon_en  = 1'b1;
  endtask

  task automatic test_delays();
    int s;
    start_frame(4, 2, 3, 2, s);
    wait_idle(40);
  endtask

  task automatic test_back_to_back();
    int s;
    int v0;
    v0 = nvld;
    start_frame(3, 3, 0, 0, s);
    wait_idle(40);
    total++;
    if (nvld - v0 !== 9) begin
      bad++;
      $display("FAIL b2b_count got=%0d want 9", nvld - v0);
    end
  endtask

  task automatic test_empty();
    int s;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL empty_busy_pre got=%b want 0", busy);
    end
    start_frame(0, 5, 0, 0, s);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      total++;
      if (busy !== (k <= 2)) begin
        bad++;
        $display("FAIL empty_busy rel=%0d got=%b want %b", cyc - s, busy, k <= 2);
      end
    end
    wait_idle(10);
    start_frame(3, 0, 2, 1, s);
    wait_idle(10);
  endtask

  task automatic test_ignore_midframe();
    int s;
    int v0;
    int d0;
    v0 = nvld;
    d0 = ndone;
    start_frame(4, 2, 0, 1, s);
    @(posedge clk);
    #1;
    i_start = 1'b1;
    i_width = 12'd7;
    i_su    = 12'd5;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    wait_idle(40);
    total++;
    if (nvld - v0 !== 8 || ndone - d0 !== 1) begin
      bad++;
      $display("FAIL ignore vld=%0d done=%0d want 8 1", nvld - v0, ndone - d0);
    end
  endtask

  task automatic test_midreset();
    int s;
    start_frame(4, 2, 3, 2, s);
    repeat (7) @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b0;
    flush();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ((cyc - s) !== 9 ||
        {re, addr, pixel, vld, sol, sof, busy, done} !== '0) begin
      bad++;
      $display("FAIL midreset rel=%0d re=%b addr=%h px=%h vld=%b busy=%b done=%b want rel 9 all 0",
               cyc - s, re, addr, pixel, vld, busy, done);
    end
    last_px = '0;
    mon_en  = 1'b1;
    start_frame(4, 2, 3, 2, s);
    wait_idle(40);
  endtask

  task automatic test_big_wrap();
    int s;
    int v0;
    v0 = nvld;
    start_frame(256, 256, 0, 0, s);
    wait_idle(70000);
    total++;
    if (nvld - v0 !== 65536) begin
      bad++;
      $display("FAIL big_count got=%0d want 65536", nvld - v0);
    end
    start_frame(2, 1, 0, 0, s);
    wait_idle(20);
  endtask

  initial begin
    test_reset();
    test_delays();
    test_back_to_back();
    test_empty();
    test_ignore_midframe();
    test_midreset();
    test_big_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
